// File: rtl/fsm_word_scheduler_pkg.sv
// Shared types and defaults for the word scheduler: controller and detector
// state encodings plus the default requester count and word width.
package fsm_word_scheduler_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_WORD_W = 8;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'd0,
    CTRL_CLEAR = 2'd1,
    CTRL_SHIFT = 2'd2,
    CTRL_DONE  = 2'd3
  } ctrl_state_e;

  typedef enum logic [2:0] {
    CORE_A = 3'd0,
    CORE_B = 3'd1,
    CORE_C = 3'd2,
    CORE_D = 3'd3,
    CORE_E = 3'd4
  } core_state_e;

endpackage

// File: rtl/fsm_word_scheduler_core.sv
// Bit-serial Moore detector shared by all requesters; z is high in D and E.
module bit_fsm_core
  import fsm_word_scheduler_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic z
);

  core_state_e state_q, state_d;

  always_comb begin
    state_d = CORE_A;
    case (state_q)
      CORE_A:  state_d = x ? CORE_B : CORE_A;
      CORE_B:  state_d = x ? CORE_E : CORE_B;
      CORE_C:  state_d = x ? CORE_B : CORE_C;
      CORE_D:  state_d = x ? CORE_C : CORE_B;
      CORE_E:  state_d = x ? CORE_E : CORE_D;
      default: state_d = CORE_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= CORE_A;
    else       state_q <= state_d;
  end

  assign z = (state_q == CORE_D) || (state_q == CORE_E);

endmodule

// File: rtl/fsm_word_scheduler.sv
// Round-robin scheduler that time-shares one bit-serial detector among
// N_REQ requesters and returns a per-bit detector vector for each word.
module fsm_word_scheduler
  import fsm_word_scheduler_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WORD_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       res_valid,
  output logic [$clog2(N_REQ)-1:0]   res_id,
  output logic [WORD_W-1:0]          res_z,
  input  logic                       res_ready,
  output logic                       busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(WORD_W);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WORD_W - 1);
  localparam logic [IDW-1:0] LAST_REQ = IDW'(N_REQ - 1);

  ctrl_state_e       state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] zvec_q, zvec_d;
  logic              valid_q, valid_d;
  logic              capture_q, capture_d;

  logic              anyValid;
  logic [IDW-1:0]    grantIdx;
  logic [IDW-1:0]    nextPtr;
  logic [WORD_W-1:0] selWord;
  logic              coreX, coreZ, coreReset;

  // Walk downward over offsets so the last hit is the nearest valid
  // requester at or above the pointer, wrapping past N_REQ-1.
  always_comb begin
    int j;
    logic [IDW-1:0] cand;
    j        = 0;
    cand     = '0;
    anyValid = 1'b0;
    grantIdx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      cand = IDW'(j);
      if (req_valid[cand]) begin
        anyValid = 1'b1;
        grantIdx = cand;
      end
    end
  end

  always_comb begin
    selWord = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grantIdx == IDW'(i)) selWord = req_data[i*WORD_W +: WORD_W];
    end
  end

  assign nextPtr = (grantIdx == LAST_REQ) ? '0 : grantIdx + 1'b1;

  always_comb begin
    req_ready = '0;
    if (state_q == CTRL_IDLE && anyValid && !reset) req_ready[grantIdx] = 1'b1;
  end

  // The core's z reflects a bit one cycle after it is fed, so captures lag
  // SHIFT by one cycle and the last capture lands in the first DONE cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    word_d    = word_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    zvec_d    = zvec_q;
    valid_d   = valid_q;
    capture_d = (state_q == CTRL_SHIFT);
    if (capture_q) zvec_d = {zvec_q[WORD_W-2:0], coreZ};
    case (state_q)
      CTRL_IDLE: begin
        if (anyValid) begin
          word_d  = selWord;
          id_d    = grantIdx;
          ptr_d   = nextPtr;
          state_d = CTRL_CLEAR;
        end
      end
      CTRL_CLEAR: begin
        cnt_d   = '0;
        state_d = CTRL_SHIFT;
      end
      CTRL_SHIFT: begin
        word_d = word_q << 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) state_d = CTRL_DONE;
      end
      CTRL_DONE: begin
        if (capture_q) begin
          valid_d = 1'b1;
        end else if (valid_q && res_ready) begin
          valid_d = 1'b0;
          state_d = CTRL_IDLE;
        end
      end
      default: state_d = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CTRL_IDLE;
      ptr_q     <= '0;
      word_q    <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      zvec_q    <= '0;
      valid_q   <= 1'b0;
      capture_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      word_q    <= word_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      zvec_q    <= zvec_d;
      valid_q   <= valid_d;
      capture_q <= capture_d;
    end
  end

  assign coreX     = (state_q == CTRL_SHIFT) && word_q[WORD_W-1];
  assign coreReset = reset || (state_q == CTRL_CLEAR);

  bit_fsm_core uCore (
    .clk   (clk),
    .reset (coreReset),
    .x     (coreX),
    .z     (coreZ)
  );

  assign res_valid = valid_q;
  assign res_id    = id_q;
  assign res_z     = zvec_q;
  assign busy      = (state_q != CTRL_IDLE);

endmodule

// File: tb/tb_fsm_word_scheduler.sv
// Directed bench for fsm_word_scheduler with a reference detector model and a
// queue of expected results pushed at each transfer and popped at each result.
module tb_fsm_word_scheduler;

  localparam int NR = 4;
  localparam int WW = 8;

  logic          clk;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [NR*WW-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          res_valid;
  logic [1:0]    res_id;
  logic [WW-1:0] res_z;
  logic          res_ready;
  logic          busy;

  typedef struct {
    int id;
    int z;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;
  int   ptrModel   = 0;

  fsm_word_scheduler #(.N_REQ(NR), .WORD_W(WW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_z     (res_z),
    .res_ready (res_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NR-1:0] valid, input logic [NR*WW-1:0] data,
                               input logic ready);
    req_valid = valid;
    req_data  = data;
    res_ready = ready;
  endtask

  // Independent reference for the detector: returns the per-bit z vector.
  function automatic int modelZ(input logic [WW-1:0] word);
    int s;
    int r;
    s = 0;
    r = 0;
    for (int k = 0; k < WW; k++) begin
      if (word[WW-1-k]) begin
        case (s)
          0: s = 1; 1: s = 4; 2: s = 1; 3: s = 2; default: s = 4;
        endcase
      end else begin
        case (s)
          0: s = 0; 1: s = 1; 2: s = 2; 3: s = 1; default: s = 3;
        endcase
      end
      r = (r << 1) | ((s >= 3) ? 1 : 0);
    end
    return r;
  endfunction

  function automatic int modelGrant(input logic [NR-1:0] valid);
    for (int i = 0; i < NR; i++) begin
      if (valid[(ptrModel + i) % NR]) return (ptrModel + i) % NR;
    end
    return 0;
  endfunction

  task automatic applyReset();
    reset = 1'b1;
    applyStimulus('0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    ptrModel = 0;
  endtask

  // One full request/result exchange starting from IDLE, #1 after an edge.
  task automatic runOne(input logic [NR-1:0] valid, input logic [NR*WW-1:0] data,
                        input int expId, input int expZ, input int stall,
                        input bit keepValid, input string tag);
    exp_t e;
    int   g;
    int   n;
    bit   seen;
    applyStimulus(valid, data, 1'b0);
    #1;
    g = (expId >= 0) ? expId : modelGrant(valid);
    checkOutput({tag, ".grant"}, 32'(req_ready), 32'(1 << g));
    ptrModel = (g + 1) % NR;
    e.id = g;
    e.z  = (expZ >= 0) ? expZ : modelZ(data[g*WW +: WW]);
    expQ.push_back(e);
    @(posedge clk);
    #1;
    req_data = {$urandom, $urandom};
    if (!keepValid) req_valid = '0;
    checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
    checkOutput({tag, ".readyLowBusy"}, 32'(req_ready), 32'd0);
    n    = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (res_valid === 1'b1) seen = 1'b1;
    end
    checkOutput({tag, ".latency"}, 32'(n), 32'(WW + 2));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, ".stallValid"}, 32'(res_valid), 32'd1);
      checkOutput({tag, ".stallZ"}, 32'(res_z), 32'(expQ[0].z));
      checkOutput({tag, ".stallId"}, 32'(res_id), 32'(expQ[0].id));
      checkOutput({tag, ".stallReady"}, 32'(req_ready), 32'd0);
    end
    e = expQ.pop_front();
    checkOutput({tag, ".resId"}, 32'(res_id), 32'(e.id));
    checkOutput({tag, ".resZ"}, 32'(res_z), 32'(e.z));
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checkOutput({tag, ".idleAfter"}, 32'(busy), 32'd0);
    checkOutput({tag, ".validDrop"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    int rrIds[5];
    bit sawValid;
    rrIds = '{0, 1, 2, 3, 0};

    reset = 1'b1;
    applyStimulus('1, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.resValid", 32'(res_valid), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.reqReady", 32'(req_ready), 32'd0);
    checkOutput("reset.resId", 32'(res_id), 32'd0);
    checkOutput("reset.resZ", 32'(res_z), 32'd0);
    applyStimulus('0, '0, 1'b0);
    reset    = 1'b0;
    ptrModel = 0;
    $display("[TB] single request");
    runOne(4'b0001, 32'h0000_0098, 0, 'h1C, 0, 1'b0, "single98");

    $display("[TB] boundary words");
    runOne(4'b0001, 32'h0000_00FF, 0, 'h7F, 0, 1'b0, "wordFF");
    runOne(4'b0001, 32'h0000_0000, 0, 'h00, 0, 1'b0, "word00");
    runOne(4'b0001, 32'h0000_00C0, 0, 'h60, 0, 1'b0, "wordC0");

    $display("[TB] back-pressure");
    runOne(4'b1000, 32'hA500_0000, 3, -1, 5, 1'b0, "stall");

    $display("[TB] reset during shift");
    applyStimulus(4'b0001, 32'h0000_00E7, 1'b0);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    ptrModel = 0;
    checkOutput("abort.idle", 32'(busy), 32'd0);
    checkOutput("abort.resValid", 32'(res_valid), 32'd0);
    checkOutput("abort.resZ", 32'(res_z), 32'd0);
    req_valid = '1;
    #1;
    checkOutput("abort.ptrZero", 32'(req_ready), 32'd1);
    req_valid = '0;
    sawValid  = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (res_valid !== 1'b0) sawValid = 1'b1;
    end
    checkOutput("abort.noResult", 32'(sawValid), 32'd0);
    runOne(4'b0001, 32'h0000_0098, 0, 'h1C, 0, 1'b0, "afterAbort");

    $display("[TB] round-robin");
    applyReset();
    for (int t = 0; t < 5; t++) begin
      runOne(4'b1111, {$urandom}, rrIds[t], -1, 0, 1'b1, $sformatf("rr%0d", t));
    end

    $display("[TB] wrap-around");
    runOne(4'b0100, {$urandom}, 2, -1, 0, 1'b0, "wrapSetP3");
    runOne(4'b0110, {$urandom}, 1, -1, 0, 1'b0, "wrapGrant1");
    runOne(4'b0110, {$urandom}, 2, -1, 0, 1'b0, "wrapP2");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
